mod_counter_fsm: RTL and testbench

- Parametrised modulo-N state counter; next generation of the team's 2-bit count-enable FSM, which counted 0→3 and flagged the top state.
- Adds the following:
  - configurable width and modulus
  - up/down direction
  - synchronous load and clear
  - wrap or saturate mode
  - registered event pulses
- Used as a sequencer/timer building block in the digital-systems labs.

---
 rtl/counter_pkg.sv | 27 ++
 rtl/mod_counter_next.sv | 49 ++++
 rtl/mod_counter_fsm.sv | 110 +++++++++++
 tb/tb_mod_counter_fsm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants, operation type and parameter check for the modulo counter
package counter_pkg;

  // Direction encoding on the up input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values of the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Operation chosen on an edge, listed lowest to highest priority.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_COUNT,
    OP_LOAD,
    OP_CLEAR
  } op_e;

  // A modulus is legal when 2 <= modulus <= 2**width.
  function automatic bit modulus_legal(int width, int modulus);
    if (width < 1 || modulus < 2) return 1'b0;
    if (width >= 31) return 1'b1;
    return modulus <= (1 << width);
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// rtl/mod_counter_next.sv - combinational next count and boundary flag for a modulo counter
// Ports:
//   count_i    current count (always 0..MODULUS-1)
//   up_i       direction, DIR_UP increments
//   cnt_i      count enable
//   next_o     count after this edge if counting is the selected operation
//   boundary_o high when counting at the terminal value of the current direction
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_i,
  input  logic             cnt_i,
  output logic [WIDTH-1:0] next_o,
  output logic             boundary_o
);

  // Top value compared with one extra bit so MODULUS == 2**WIDTH still works.
  localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  logic at_top;
  logic at_bottom;
  logic at_end;

  assign at_top     = ({1'b0, count_i} == TOP_EXT);
  assign at_bottom  = (count_i == '0);
  assign at_end     = (up_i == DIR_UP) ? at_top : at_bottom;
  assign boundary_o = cnt_i & at_end;

  // Away from the ends the +/-1 cannot leave 0..MODULUS-1, so no modulo is needed.
  always_comb begin
    next_o = count_i;
    if (cnt_i) begin
      if (at_end) begin
        if (SATURATE != MODE_SAT) begin
          next_o = (up_i == DIR_UP) ? '0 : TOP;
        end
      end else begin
        next_o = (up_i == DIR_UP) ? count_i + WIDTH'(1) : count_i - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mod_counter_fsm.sv
// rtl/mod_counter_fsm.sv - parametrised modulo-N up/down counter with load, clear and event pulses
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   cnt, up        count enable and direction
//   load           synchronous load of load_value (out-of-range loads clamp to MODULUS-1)
//   clear          synchronous clear, highest priority
//   count          registered state
//   y              count == MODULUS-1
//   tc             terminal value for the current direction
//   wrap           pulse the cycle after a counting edge at the terminal value
//   load_err       pulse the cycle after an out-of-range load
module mod_counter_fsm
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cnt,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             y,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_counter_fsm: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] next_count;
  logic             boundary;
  logic             load_in_range;
  op_e              op;

  mod_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .count_i   (count_q),
    .up_i      (up),
    .cnt_i     (cnt),
    .next_o    (next_count),
    .boundary_o(boundary)
  );

  assign load_in_range = ({1'b0, load_value} < MOD_EXT);

  always_comb begin
    op = OP_HOLD;
    if (clear)     op = OP_CLEAR;
    else if (load) op = OP_LOAD;
    else if (cnt)  op = OP_COUNT;
  end

  // Pulses default low so they last exactly one cycle.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    case (op)
      OP_CLEAR: count_d = '0;
      OP_LOAD: begin
        if (load_in_range) begin
          count_d = load_value;
        end else begin
          count_d    = TOP;
          load_err_d = 1'b1;
        end
      end
      OP_COUNT: begin
        count_d = next_count;
        wrap_d  = boundary;
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign y        = (count_q == TOP);
  assign tc       = (up == DIR_UP) ? (count_q == TOP) : (count_q == '0);

endmodule

// File: tb/tb_mod_counter_fsm.sv
// tb/tb_mod_counter_fsm.sv - self-checking bench for mod_counter_fsm
module tb_mod_counter_fsm;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cnt = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       clear = 1'b0;

  logic [3:0] count_v [N];
  logic [1:0] count_c;
  logic       y_v [N];
  logic       tc_v [N];
  logic       wrap_v [N];
  logic       err_v [N];

  int mods   [N] = '{10, 10, 4, 16};
  int widths [N] = '{4, 4, 2, 4};
  int sats   [N] = '{0, 1, 0, 0};

  int mc [N];
  int mw [N];
  int me [N];

  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  mod_counter_fsm #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
    .clock(clock), .reset(reset), .cnt(cnt), .up(up), .load(load),
    .load_value(load_value), .clear(clear), .count(count_v[0]),
    .y(y_v[0]), .tc(tc_v[0]), .wrap(wrap_v[0]), .load_err(err_v[0]));

  mod_counter_fsm #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (
    .clock(clock), .reset(reset), .cnt(cnt), .up(up), .load(load),
    .load_value(load_value), .clear(clear), .count(count_v[1]),
    .y(y_v[1]), .tc(tc_v[1]), .wrap(wrap_v[1]), .load_err(err_v[1]));

  mod_counter_fsm #(.WIDTH(2), .MODULUS(4), .SATURATE(0)) u_c (
    .clock(clock), .reset(reset), .cnt(cnt), .up(up), .load(load),
    .load_value(load_value[1:0]), .clear(clear), .count(count_c),
    .y(y_v[2]), .tc(tc_v[2]), .wrap(wrap_v[2]), .load_err(err_v[2]));

  assign count_v[2] = {2'b00, count_c};

  mod_counter_fsm #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_d (
    .clock(clock), .reset(reset), .cnt(cnt), .up(up), .load(load),
    .load_value(load_value), .clear(clear), .count(count_v[3]),
    .y(y_v[3]), .tc(tc_v[3]), .wrap(wrap_v[3]), .load_err(err_v[3]));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain modulo arithmetic on integers.
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mc[k] = 0; mw[k] = 0; me[k] = 0;
    end
  endtask

  task automatic model_step(input bit c, input bit l, input bit e, input bit u, input int lv);
    for (int k = 0; k < N; k++) begin
      int m;
      int lvk;
      bit at_end;
      m   = mods[k];
      lvk = lv % (1 << widths[k]);
      mw[k] = 0;
      me[k] = 0;
      if (c) begin
        mc[k] = 0;
      end else if (l) begin
        if (lvk >= m) begin
          mc[k] = m - 1;
          me[k] = 1;
        end else begin
          mc[k] = lvk;
        end
      end else if (e) begin
        at_end = u ? (mc[k] == m - 1) : (mc[k] == 0);
        mw[k]  = at_end;
        if (!(at_end && sats[k] == 1))
          mc[k] = u ? (mc[k] + 1) % m : (mc[k] + m - 1) % m;
      end
    end
  endtask

  task automatic check_comb(input string tag);
    for (int k = 0; k < N; k++) begin
      int m;
      m = mods[k];
      chk($sformatf("%s y[%0d]", tag, k), int'(y_v[k]), int'(mc[k] == m - 1));
      chk($sformatf("%s tc[%0d]", tag, k), int'(tc_v[k]),
          up ? int'(mc[k] == m - 1) : int'(mc[k] == 0));
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s count[%0d]", tag, k), int'(count_v[k]), mc[k]);
      chk($sformatf("%s wrap[%0d]", tag, k), int'(wrap_v[k]), mw[k]);
      chk($sformatf("%s load_err[%0d]", tag, k), int'(err_v[k]), me[k]);
    end
  endtask

  // Called mid-cycle: drive, check combinational outputs, clock once, check registers.
  task automatic step(input string tag, input bit c, input bit l, input bit e, input bit u, input int lv);
    clear = c; load = l; cnt = e; up = u; load_value = 4'(lv);
    #1;
    check_comb(tag);
    @(posedge clock);
    model_step(c, l, e, u, lv);
    #1;
    check_regs(tag);
  endtask

  typedef struct {
    bit c;
    bit l;
    bit e;
    bit u;
    int lv;
    int exp_count;
    int exp_wrap;
    int exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1, 0, 0, 1, 0,  0, 0, 0};
    vecs[1]  = '{0, 1, 1, 1, 12, 9, 0, 1};
    vecs[2]  = '{0, 0, 0, 1, 0,  9, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 0,  0, 1, 0};
    vecs[4]  = '{0, 1, 1, 1, 3,  3, 0, 0};
    vecs[5]  = '{1, 1, 1, 1, 12, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 0,  9, 1, 0};
    vecs[7]  = '{0, 0, 1, 0, 0,  8, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 10, 9, 0, 1};
    vecs[9]  = '{0, 1, 0, 0, 9,  9, 0, 0};
    vecs[10] = '{0, 1, 0, 1, 15, 9, 0, 1};
    vecs[11] = '{0, 0, 1, 0, 0,  8, 0, 0};

    model_reset();
    repeat (2) @(posedge clock);
    #2;
    check_regs("reset");
    check_comb("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Asynchronous reset between edges at count 7.
    step("pre", 1, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step("to7", 0, 0, 1, 1, 0);
    chk("hand count before reset", int'(count_v[0]), 7);
    #2;
    reset = 1'b1;
    up = 1'b0;
    #1;
    model_reset();
    chk("hand async count", int'(count_v[0]), 0);
    chk("hand async wrap", int'(wrap_v[0]), 0);
    chk("hand async y", int'(y_v[0]), 0);
    chk("hand async tc", int'(tc_v[0]), 1);
    #1;
    reset = 1'b0;

    // Count up 12 cycles from 0.
    for (int i = 0; i < 12; i++) begin
      step("up12", 0, 0, 1, 1, 0);
      chk($sformatf("hand up count %0d", i), int'(count_v[0]), (i + 1) % 10);
      chk($sformatf("hand up wrap %0d", i), int'(wrap_v[0]), int'(i == 9));
      chk($sformatf("hand up y %0d", i), int'(y_v[0]), int'((i + 1) % 10 == 9));
    end

    // Count down from 0.
    step("clr", 1, 0, 0, 1, 0);
    up = 1'b0;
    #1;
    chk("hand tc at 0 down", int'(tc_v[0]), 1);
    for (int i = 0; i < 3; i++) begin
      step("down", 0, 0, 1, 0, 0);
      chk($sformatf("hand down count %0d", i), int'(count_v[0]), 9 - i);
      chk($sformatf("hand down wrap %0d", i), int'(wrap_v[0]), int'(i == 0));
    end

    // Saturate instance held at 9.
    step("ld9", 0, 1, 0, 1, 9);
    for (int i = 0; i < 3; i++) begin
      step("sat", 0, 0, 1, 1, 0);
      chk($sformatf("hand sat count %0d", i), int'(count_v[1]), 9);
      chk($sformatf("hand sat wrap %0d", i), int'(wrap_v[1]), 1);
    end

    // Modulus 4 on two bits.
    step("clr", 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step("m4", 0, 0, 1, 1, 0);
      chk($sformatf("hand m4 count %0d", i), int'(count_v[2]), (i + 1) % 4);
      chk($sformatf("hand m4 y %0d", i), int'(y_v[2]), int'((i + 1) % 4 == 3));
    end

    // Modulus 16 on four bits wraps 15 to 0.
    step("ld15", 0, 1, 0, 1, 15);
    chk("hand m16 load", int'(count_v[3]), 15);
    step("m16", 0, 0, 1, 1, 0);
    chk("hand m16 count", int'(count_v[3]), 0);
    chk("hand m16 wrap", int'(wrap_v[3]), 1);

    // Vector table for the modulus-10 wrapping instance.
    for (int i = 0; i < 12; i++) begin
      step("vec", vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].lv);
      chk($sformatf("vec%0d count", i), int'(count_v[0]), vecs[i].exp_count);
      chk($sformatf("vec%0d wrap", i), int'(wrap_v[0]), vecs[i].exp_wrap);
      chk($sformatf("vec%0d load_err", i), int'(err_v[0]), vecs[i].exp_err);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit rc, rl, re, ru;
      rc = ($urandom_range(0, 15) == 0);
      rl = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) != 0);
      ru = ($urandom_range(0, 2) != 0);
      step("rand", rc, rl, re, ru, int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
